// File: rtl/pong_pkg.sv
// rtl/pong_pkg.sv - shared types and constants for the Pong match sequencer
package pong_pkg;

    localparam int SCORE_W = 4;
    localparam int TIMER_W = 10;

    localparam logic SERVE_LEFT  = 1'b0;
    localparam logic SERVE_RIGHT = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SERVE,
        ST_PLAY,
        ST_POINT,
        ST_GAME_OVER
    } match_state_t;

    function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] s);
        return (s == '1) ? s : s + 1'b1;
    endfunction

endpackage

// File: rtl/pong_frame_timer.sv
// rtl/pong_frame_timer.sv - loadable frame down-counter that holds at zero
module pong_frame_timer
    import pong_pkg::*;
(
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_load,
    input  logic [TIMER_W-1:0] i_load_val,
    output logic               o_done
);

    logic [TIMER_W-1:0] r_count;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (r_count != '0) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_done = (r_count == '0);

endmodule

// File: rtl/pong_match_ctrl.sv
// rtl/pong_match_ctrl.sv - round/serve/score sequencer for the Pong datapath
// Optional win-by-two rule with deuce collapse: PONG_WIN_BY_TWO_EN
module pong_match_ctrl
    import pong_pkg::*;
#(
    parameter int WIN_SCORE    = 7,
    parameter int SERVE_FRAMES = 60,
    parameter int POINT_FRAMES = 90
) (
    input  logic               frame_clk,
    input  logic               Reset_n,
    input  logic               start_key,
    input  logic               miss_left,
    input  logic               miss_right,
    output logic               resetB,
    output logic               play_en,
    output logic               serve_dir,
    output logic [SCORE_W-1:0] score1,
    output logic [SCORE_W-1:0] score2,
    output logic               game_over,
    output logic               winner
);

    match_state_t       r_state;
    logic               r_start_q;
    logic               r_reset_b;
    logic               r_play_en;
    logic               r_serve_dir;
    logic [SCORE_W-1:0] r_score1;
    logic [SCORE_W-1:0] r_score2;
    logic               r_game_over;
    logic               r_winner;
    logic               r_scorer;
    logic               r_scored;

    match_state_t       w_next_state;
    logic               w_start_rise;
    logic               w_load;
    logic [TIMER_W-1:0] w_load_val;
    logic               w_timer_done;
    logic [SCORE_W-1:0] w_score1_nxt;
    logic [SCORE_W-1:0] w_score2_nxt;
    logic               w_serve_dir_nxt;
    logic               w_scorer_nxt;
    logic               w_scored_nxt;
    logic               w_winner_nxt;
    logic [SCORE_W-1:0] w_p1_s1;
    logic [SCORE_W-1:0] w_p1_s2;
    logic [SCORE_W-1:0] w_p2_s1;
    logic [SCORE_W-1:0] w_p2_s2;
    logic [SCORE_W-1:0] w_scorer_pts;
    logic               w_win;

    assign w_start_rise = start_key & ~r_start_q;

    pong_frame_timer u_timer (
        .i_clk      (frame_clk),
        .i_rst_n    (Reset_n),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .o_done     (w_timer_done)
    );

    // Scores that would result from a point to player 1 (w_p1_*) or player 2 (w_p2_*)
    always_comb begin
`ifdef PONG_WIN_BY_TWO_EN
        if (r_score1 == '1) begin
            w_p1_s1 = r_score1;
            w_p1_s2 = (r_score2 != '0) ? r_score2 - 1'b1 : r_score2;
        end else begin
            w_p1_s1 = r_score1 + 1'b1;
            w_p1_s2 = r_score2;
        end
        if (r_score2 == '1) begin
            w_p2_s2 = r_score2;
            w_p2_s1 = (r_score1 != '0) ? r_score1 - 1'b1 : r_score1;
        end else begin
            w_p2_s2 = r_score2 + 1'b1;
            w_p2_s1 = r_score1;
        end
`else
        w_p1_s1 = sat_inc(r_score1);
        w_p1_s2 = r_score2;
        w_p2_s1 = r_score1;
        w_p2_s2 = sat_inc(r_score2);
`endif
    end

    assign w_scorer_pts = r_scorer ? r_score2 : r_score1;

`ifdef PONG_WIN_BY_TWO_EN
    logic [SCORE_W-1:0] w_other_pts;
    assign w_other_pts = r_scorer ? r_score1 : r_score2;
    assign w_win = r_scored
                 && (w_scorer_pts >= SCORE_W'(WIN_SCORE))
                 && ({1'b0, w_scorer_pts} >= ({1'b0, w_other_pts} + 5'd2));
`else
    assign w_win = r_scored && (w_scorer_pts == SCORE_W'(WIN_SCORE));
`endif

    always_comb begin
        w_next_state    = r_state;
        w_load          = 1'b0;
        w_load_val      = TIMER_W'(SERVE_FRAMES);
        w_score1_nxt    = r_score1;
        w_score2_nxt    = r_score2;
        w_serve_dir_nxt = r_serve_dir;
        w_scorer_nxt    = r_scorer;
        w_scored_nxt    = r_scored;
        w_winner_nxt    = r_winner;
        case (r_state)
            ST_IDLE, ST_GAME_OVER: begin
                if (w_start_rise) begin
                    w_next_state    = ST_SERVE;
                    w_load          = 1'b1;
                    w_score1_nxt    = '0;
                    w_score2_nxt    = '0;
                    w_serve_dir_nxt = SERVE_RIGHT;
                    w_scored_nxt    = 1'b0;
                end
            end
            ST_SERVE: begin
                if (w_timer_done) begin
                    w_next_state = ST_PLAY;
                end
            end
            ST_PLAY: begin
                if (miss_left || miss_right) begin
                    w_next_state = ST_POINT;
                    w_load       = 1'b1;
                    w_load_val   = TIMER_W'(POINT_FRAMES);
                    w_scored_nxt = miss_left ^ miss_right;
                    if (miss_left && !miss_right) begin
                        w_score1_nxt    = w_p2_s1;
                        w_score2_nxt    = w_p2_s2;
                        w_serve_dir_nxt = SERVE_LEFT;
                        w_scorer_nxt    = 1'b1;
                    end else if (miss_right && !miss_left) begin
                        w_score1_nxt    = w_p1_s1;
                        w_score2_nxt    = w_p1_s2;
                        w_serve_dir_nxt = SERVE_RIGHT;
                        w_scorer_nxt    = 1'b0;
                    end
                end
            end
            ST_POINT: begin
                if (w_timer_done) begin
                    if (w_win) begin
                        w_next_state = ST_GAME_OVER;
                        w_winner_nxt = r_scorer;
                    end else begin
                        w_next_state = ST_SERVE;
                        w_load       = 1'b1;
                    end
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Outputs are registered from the next state so they change on the entering edge
    always_ff @(posedge frame_clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state     <= ST_IDLE;
            r_start_q   <= 1'b1;
            r_reset_b   <= 1'b0;
            r_play_en   <= 1'b0;
            r_serve_dir <= SERVE_RIGHT;
            r_score1    <= '0;
            r_score2    <= '0;
            r_game_over <= 1'b0;
            r_winner    <= 1'b0;
            r_scorer    <= 1'b0;
            r_scored    <= 1'b0;
        end else begin
            r_state     <= w_next_state;
            r_start_q   <= start_key;
            r_reset_b   <= (w_next_state == ST_SERVE) && (r_state != ST_SERVE);
            r_play_en   <= (w_next_state == ST_PLAY);
            r_serve_dir <= w_serve_dir_nxt;
            r_score1    <= w_score1_nxt;
            r_score2    <= w_score2_nxt;
            r_game_over <= (w_next_state == ST_GAME_OVER);
            r_winner    <= w_winner_nxt;
            r_scorer    <= w_scorer_nxt;
            r_scored    <= w_scored_nxt;
        end
    end

    assign resetB    = r_reset_b;
    assign play_en   = r_play_en;
    assign serve_dir = r_serve_dir;
    assign score1    = r_score1;
    assign score2    = r_score2;
    assign game_over = r_game_over;
    assign winner    = r_winner;

endmodule

// File: tb/tb_pong_match_ctrl.sv
// tb/tb_pong_match_ctrl.sv - directed self-checking bench for pong_match_ctrl
module tb_pong_match_ctrl;

    logic       frame_clk = 1'b0;
    logic       Reset_n;
    logic       start_key;
    logic       miss_left;
    logic       miss_right;
    logic       resetB;
    logic       play_en;
    logic       serve_dir;
    logic [3:0] score1;
    logic [3:0] score2;
    logic       game_over;
    logic       winner;

    int n_tests = 0;
    int n_fail  = 0;

    pong_match_ctrl dut (
        .frame_clk  (frame_clk),
        .Reset_n    (Reset_n),
        .start_key  (start_key),
        .miss_left  (miss_left),
        .miss_right (miss_right),
        .resetB     (resetB),
        .play_en    (play_en),
        .serve_dir  (serve_dir),
        .score1     (score1),
        .score2     (score2),
        .game_over  (game_over),
        .winner     (winner)
    );

    always #5 frame_clk = ~frame_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge frame_clk);
        #1;
    endtask

    // Called at (or c0 cycles after) a resetB cycle; play_en must rise 61 cycles after it
    task automatic wait_play(input int c0);
        int c;
        c = c0;
        while (!play_en && c < 300) begin
            tick();
            c++;
        end
        chk("serve_to_play_cycles", c, 61);
    endtask

    // Called in the first POINT cycle; expects 91 POINT cycles, then SERVE or GAME_OVER
    task automatic finish_point(input logic expect_over);
        int c;
        c = 0;
        while (!resetB && !game_over && c < 300) begin
            tick();
            c++;
        end
        chk("point_cycles", c, 91);
        chk("point_exit_game_over", game_over, expect_over);
        chk("point_exit_resetB", resetB, !expect_over);
    endtask

    task automatic score(input logic p2);
        if (p2) miss_left = 1'b1;
        else    miss_right = 1'b1;
        tick();
        miss_left  = 1'b0;
        miss_right = 1'b0;
    endtask

    task automatic full_point(input logic p2);
        score(p2);
        finish_point(1'b0);
        wait_play(0);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        Reset_n    = 1'b0;
        start_key  = 1'b0;
        miss_left  = 1'b0;
        miss_right = 1'b0;
        repeat (3) @(posedge frame_clk);
        #1;
        chk("rst_resetB", resetB, 0);
        chk("rst_play_en", play_en, 0);
        chk("rst_serve_dir", serve_dir, 1);
        chk("rst_score1", score1, 0);
        chk("rst_score2", score2, 0);
        chk("rst_game_over", game_over, 0);
        chk("rst_winner", winner, 0);
        Reset_n = 1'b1;
        tick();
        tick();
        chk("idle_play_en", play_en, 0);
        chk("idle_resetB", resetB, 0);

        start_key = 1'b1;
        tick();
        chk("start_resetB", resetB, 1);
        chk("start_serve_dir", serve_dir, 1);
        chk("start_play_en", play_en, 0);
        start_key = 1'b0;
        tick();
        chk("resetB_one_cycle", resetB, 0);
        wait_play(1);

        score(1'b0);
        chk("mr_score1", score1, 1);
        chk("mr_score2", score2, 0);
        chk("mr_play_en", play_en, 0);
        chk("mr_serve_dir", serve_dir, 1);
        finish_point(1'b0);
        wait_play(0);

        miss_left  = 1'b1;
        miss_right = 1'b1;
        tick();
        miss_left  = 1'b0;
        miss_right = 1'b0;
        chk("both_score1", score1, 1);
        chk("both_score2", score2, 0);
        chk("both_play_en", play_en, 0);
        chk("both_serve_dir", serve_dir, 1);
        finish_point(1'b0);
        wait_play(0);

        for (int k = 1; k <= 7; k++) begin
            score(1'b1);
            chk("p2_score2", score2, k);
            chk("p2_serve_dir", serve_dir, 0);
            finish_point(k == 7);
            if (k < 7) wait_play(0);
        end
        chk("go_winner", winner, 1);
        chk("go_score2", score2, 7);
        chk("go_score1", score1, 1);
        chk("go_play_en", play_en, 0);
        miss_right = 1'b1;
        tick();
        miss_right = 1'b0;
        miss_left  = 1'b1;
        tick();
        miss_left  = 1'b0;
        tick();
        chk("go_ignore_score1", score1, 1);
        chk("go_ignore_score2", score2, 7);
        chk("go_hold", game_over, 1);

        start_key = 1'b1;
        tick();
        start_key = 1'b0;
        chk("restart_score1", score1, 0);
        chk("restart_score2", score2, 0);
        chk("restart_game_over", game_over, 0);
        chk("restart_resetB", resetB, 1);
        chk("restart_serve_dir", serve_dir, 1);
        wait_play(0);

        full_point(1'b0);
        full_point(1'b1);
        full_point(1'b0);
        full_point(1'b1);
        full_point(1'b0);
        chk("pre_rst_score1", score1, 3);
        chk("pre_rst_score2", score2, 2);
        chk("pre_rst_play_en", play_en, 1);
        tick();
        #2;
        Reset_n = 1'b0;
        #1;
        chk("midrst_play_en", play_en, 0);
        chk("midrst_score1", score1, 0);
        chk("midrst_score2", score2, 0);
        chk("midrst_serve_dir", serve_dir, 1);
        start_key = 1'b1;
        tick();
        tick();
        Reset_n = 1'b1;
        tick();
        tick();
        tick();
        chk("held_key_resetB", resetB, 0);
        chk("held_key_play_en", play_en, 0);
        start_key = 1'b0;
        tick();
        start_key = 1'b1;
        tick();
        start_key = 1'b0;
        chk("after_rst_start", resetB, 1);
        wait_play(0);

`ifdef PONG_WIN_BY_TWO_EN
        for (int i = 0; i < 6; i++) begin
            full_point(1'b0);
            full_point(1'b1);
        end
        chk("wb2_66_s1", score1, 6);
        chk("wb2_66_s2", score2, 6);
        score(1'b0);
        chk("wb2_76_s1", score1, 7);
        finish_point(1'b0);
        wait_play(0);
        score(1'b0);
        chk("wb2_86_s1", score1, 8);
        chk("wb2_86_s2", score2, 6);
        finish_point(1'b1);
        chk("wb2_86_winner", winner, 0);

        start_key = 1'b1;
        tick();
        start_key = 1'b0;
        wait_play(0);
        for (int i = 0; i < 14; i++) begin
            full_point(1'b0);
            full_point(1'b1);
        end
        full_point(1'b0);
        full_point(1'b1);
        chk("wb2_1515_s1", score1, 15);
        chk("wb2_1515_s2", score2, 15);
        score(1'b0);
        chk("deuce1_s1", score1, 15);
        chk("deuce1_s2", score2, 14);
        finish_point(1'b0);
        wait_play(0);
        score(1'b0);
        chk("deuce2_s1", score1, 15);
        chk("deuce2_s2", score2, 13);
        finish_point(1'b1);
        chk("deuce2_winner", winner, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
